// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: op-codes, FSM states and
// default widths.
package alu_share_arbiter_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 3;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_RSVD = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational ALU shared by both requesters; Zero and Sign are derived
// from the result here so the arbiter only has to register them.
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
#(
  parameter int ALU_Width          = DEF_DATA_W,
  parameter int ALU_Control_Signal = DEF_CTRL_W
) (
  input  logic [ALU_Width-1:0]          src_a,
  input  logic [ALU_Width-1:0]          src_b,
  input  logic [ALU_Control_Signal-1:0] alu_control,
  output logic [ALU_Width-1:0]          alu_result,
  output logic                          zero,
  output logic                          sign
);

  // Shifts take the whole src_b, so any amount >= ALU_Width yields zero.
  always_comb begin
    alu_result = '0;
    case (alu_control)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SLL: alu_result = src_a << src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_XOR: alu_result = src_a ^ src_b;
      ALU_SRL: alu_result = src_a >> src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_AND: alu_result = src_a & src_b;
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0) && (alu_control != ALU_RSVD);
  assign sign = alu_result[ALU_Width-1];

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters, with
// registered operands and registered result/flags around the ALU.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_sign,
  output logic              busy
);

  state_e              state_q, state_d;
  logic                prio_q, prio_d;
  logic                grant_q, grant_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d;
  logic                sign_q, sign_d;

  logic [DATA_W-1:0]   alu_result;
  logic                alu_zero;
  logic                alu_sign;
  logic                arb_grant;
  logic                accept;
  logic                rsp_done;

  alu_share_arbiter_alu #(
    .ALU_Width          (DATA_W),
    .ALU_Control_Signal (CTRL_W)
  ) u_alu (
    .src_a       (a_q),
    .src_b       (b_q),
    .alu_control (ctrl_q),
    .alu_result  (alu_result),
    .zero        (alu_zero),
    .sign        (alu_sign)
  );

  // On a tie the prio port wins; otherwise whichever port is valid.
  assign arb_grant = (req0_valid && req1_valid) ? prio_q : req1_valid;
  assign accept    = (state_q == ST_IDLE) && (req0_valid || req1_valid);
  assign rsp_done  = (state_q == ST_RESP) && (grant_q ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    grant_d    = grant_q;
    a_d        = a_q;
    b_d        = b_q;
    ctrl_d     = ctrl_q;
    result_d   = result_q;
    zero_d     = zero_q;
    sign_d     = sign_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req0_ready = !arb_grant;
          req1_ready = arb_grant;
          grant_d    = arb_grant;
          a_d        = arb_grant ? req1_a    : req0_a;
          b_d        = arb_grant ? req1_b    : req0_b;
          ctrl_d     = arb_grant ? req1_ctrl : req0_ctrl;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = alu_result;
        zero_d   = alu_zero;
        sign_d   = alu_sign;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        rsp0_valid = !grant_q;
        rsp1_valid = grant_q;
        if (rsp_done) begin
          prio_d  = !grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      prio_q   <= 1'b0;
      grant_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      grant_q  <= grant_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
    end
  end

  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_sign   = sign_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
